// File: rtl/bias_pingpong_if.sv
// bias_pingpong_if: DMA load stream and conv-engine read bus of the bias ping-pong store.
interface bias_pingpong_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
);
  logic                  load_start;
  logic [31:0]           load_bytes;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  load_done;
  logic                  load_ovf;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_avail;
  logic [ADDR_WIDTH:0]   rd_count;
  logic                  rd_release;
  logic [1:0]            bank_full;
  modport slave (
    input  load_start, load_bytes, in_data, in_valid, rd_en, rd_addr, rd_release,
    output load_ready, in_ready, load_done, load_ovf, rd_data, rd_valid, rd_avail, rd_count, bank_full
  );
  modport master (
    output load_start, load_bytes, in_data, in_valid, rd_en, rd_addr, rd_release,
    input  load_ready, in_ready, load_done, load_ovf, rd_data, rd_valid, rd_avail, rd_count, bank_full
  );
endinterface

// File: rtl/bias_pingpong_buffer.sv
// bias_pingpong_buffer: two-bank bias store, one bank filled by DMA while the other is read.
module bias_pingpong_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 320,
  parameter int ADDR_WIDTH = 9
) (
  input logic            clk,
  input logic            rst,
  bias_pingpong_if.slave bus
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int CW  = ADDR_WIDTH + 1;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_LOAD = 1'b1;
  logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];
  logic [0:0]            r_state;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [1:0]            r_full;
  logic [CW-1:0]         r_count [2];
  logic [CW-1:0]         r_words;
  logic [CW-1:0]         r_wr_ptr;
  logic                  r_load_done;
  logic                  r_ovf;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [32:0]           w_words_raw;
  logic                  w_ovf;
  logic [CW-1:0]         w_words;
  logic                  w_load_ready;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_last;
  logic [CW-1:0]         w_wr_idx;
  logic [CW-1:0]         w_rd_addr;
  logic [CW-1:0]         w_rd_idx;
  logic                  w_rd_avail;
  logic                  w_rd;
  logic                  w_rd_hit;
  logic                  w_release;
  // 33-bit sum so byte counts near 2^32 cannot wrap before the ceiling divide
  always_comb begin
    w_words_raw  = ({1'b0, bus.load_bytes} + 33'(BPW - 1)) / 33'(BPW);
    w_ovf        = w_words_raw > 33'(DEPTH);
    w_words      = w_ovf ? CW'(DEPTH) : w_words_raw[CW-1:0];
    w_load_ready = r_state == W_IDLE && !r_full[r_wr_bank];
    w_accept     = w_load_ready && bus.load_start && |bus.load_bytes;
    w_beat       = r_state == W_LOAD && bus.in_valid;
    w_last       = w_beat && r_wr_ptr == r_words - CW'(1);
    w_wr_idx     = r_wr_bank ? CW'(DEPTH) + r_wr_ptr : r_wr_ptr;
    w_rd_addr    = {1'b0, bus.rd_addr};
    w_rd_idx     = r_rd_bank ? CW'(DEPTH) + w_rd_addr : w_rd_addr;
    w_rd_avail   = r_full[r_rd_bank];
    w_rd         = bus.rd_en && w_rd_avail;
    w_rd_hit     = w_rd_addr < r_count[r_rd_bank];
    w_release    = bus.rd_release && w_rd_avail;
  end
  always_ff @(posedge clk)
    if (w_beat) r_mem[w_wr_idx] <= bus.in_data;
  // load completion and release always target different banks, so both bit writes may land together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= W_IDLE;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_full      <= 2'b00;
      r_count[0]  <= '0;
      r_count[1]  <= '0;
      r_words     <= '0;
      r_wr_ptr    <= '0;
      r_load_done <= 1'b0;
      r_ovf       <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_load_done <= w_last;
      r_rd_valid  <= w_rd;
      if (w_rd) r_rd_data <= w_rd_hit ? r_mem[w_rd_idx] : '0;
      if (w_accept) begin
        r_state  <= W_LOAD;
        r_words  <= w_words;
        r_wr_ptr <= '0;
        r_ovf    <= w_ovf;
      end
      if (w_beat) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_last) begin
        r_state            <= W_IDLE;
        r_full[r_wr_bank]  <= 1'b1;
        r_count[r_wr_bank] <= r_words;
        r_wr_bank          <= ~r_wr_bank;
      end
      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
    end
  end
  assign bus.load_ready = w_load_ready;
  assign bus.in_ready   = r_state == W_LOAD;
  assign bus.load_done  = r_load_done;
  assign bus.load_ovf   = r_ovf;
  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_avail   = w_rd_avail;
  assign bus.rd_count   = r_count[r_rd_bank];
  assign bus.bank_full  = r_full;
endmodule
